// File: rtl/noc_vc_splitter_if.sv
// NoC configuration package and valid/ready flit stream interface.
// Ports: valid/flit from initiator to target, ready from target to initiator.
package noc_pkg;

    localparam int FLIT_VC_W   = 2;
    localparam int FLIT_DATA_W = 16;

    typedef struct packed {
        int unsigned virtual_channels;
        int unsigned data_width;
    } noc_config_t;

    localparam noc_config_t NOC_DEFAULT_CONFIG = '{
        virtual_channels: 2,
        data_width:       FLIT_DATA_W
    };

    typedef struct packed {
        logic                   head;
        logic                   tail;
        logic [FLIT_VC_W-1:0]   vc;
        logic [FLIT_DATA_W-1:0] data;
    } noc_flit_t;

endpackage

interface noc_flit_if;
    import noc_pkg::*;

    logic      valid;
    logic      ready;
    noc_flit_t flit;

    modport initiator (output valid, output flit, input ready);
    modport target    (input valid, input flit, output ready);

endinterface

// File: rtl/noc_vc_splitter.sv
// Packet-locked demux of one flit stream into per-VC output FIFOs.
// Ports: clk, rst_n, i_clear, o_vc_available, o_error, flit_in_if, flit_out_if[].
module noc_vc_splitter
    import noc_pkg::*;
#(
    parameter noc_config_t CONFIG   = NOC_DEFAULT_CONFIG,
    parameter int          DEPTH    = 2,
    localparam int         CHANNELS = int'(CONFIG.virtual_channels)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_clear,
    output logic [CHANNELS-1:0] o_vc_available,
    output logic                o_error,
    noc_flit_if.target          flit_in_if,
    noc_flit_if.initiator       flit_out_if [CHANNELS]
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOCKED,
        DROP
    } state_e;

    state_e               state_q;
    logic [FLIT_VC_W-1:0] locked_vc_q;
    logic                 error_q;

    logic [FLIT_VC_W-1:0] sel_vc;
    logic                 in_range;
    logic                 drop;
    logic                 full_sel;
    logic                 rdy;
    logic                 accept;
    logic [CHANNELS-1:0]  full;
    logic [CHANNELS-1:0]  push;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Body/tail flits follow the locked VC; their own vc field is ignored.
    always_comb begin
        in_range = int'(flit_in_if.flit.vc) < CHANNELS;
        sel_vc   = (state_q == IDLE) ? flit_in_if.flit.vc : locked_vc_q;
        drop     = (state_q == DROP) || ((state_q == IDLE) && !in_range);
        full_sel = 1'b0;
        for (int v = 0; v < CHANNELS; v++) begin
            if (sel_vc == FLIT_VC_W'(v)) begin
                full_sel = full[v];
            end
        end
        // Only the selected VC's fullness gates the link.
        rdy = !i_clear && (drop || !full_sel);
    end

    assign flit_in_if.ready = rdy;
    assign accept           = flit_in_if.valid && rdy;
    assign o_error          = error_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            locked_vc_q <= '0;
            error_q     <= 1'b0;
        end else if (i_clear) begin
            state_q     <= IDLE;
            locked_vc_q <= '0;
        end else if (accept) begin
            unique case (state_q)
                IDLE: begin
                    if (!in_range) begin
                        error_q <= 1'b1;
                        if (!flit_in_if.flit.tail) state_q <= DROP;
                    end else if (!flit_in_if.flit.tail) begin
                        state_q     <= LOCKED;
                        locked_vc_q <= sel_vc;
                    end
                end
                LOCKED, DROP: begin
                    if (flit_in_if.flit.tail) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    for (genvar v = 0; v < CHANNELS; v++) begin : g_vc
        noc_flit_t        mem_q [DEPTH];
        logic [PTR_W-1:0] wr_q;
        logic [PTR_W-1:0] rd_q;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             avail_q;
        logic             pop;

        assign push[v] = accept && !drop && (sel_vc == FLIT_VC_W'(v));
        assign pop     = (cnt_q != '0) && flit_out_if[v].ready;
        assign full[v] = cnt_q == CNT_W'(DEPTH);

        assign flit_out_if[v].valid = cnt_q != '0;
        assign flit_out_if[v].flit  = mem_q[rd_q];
        assign o_vc_available[v]    = avail_q;

        always_comb begin
            cnt_d = cnt_q;
            if (i_clear) begin
                cnt_d = '0;
            end else if (push[v] && !pop) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else if (!push[v] && pop) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_q    <= '0;
                rd_q    <= '0;
                cnt_q   <= '0;
                avail_q <= 1'b1;
            end else begin
                cnt_q   <= cnt_d;
                // Two free slots let the upstream arbiter grant without a bubble.
                avail_q <= cnt_d <= CNT_W'(DEPTH - 2);
                if (i_clear) begin
                    wr_q <= '0;
                    rd_q <= '0;
                end else begin
                    if (push[v]) wr_q <= ptr_inc(wr_q);
                    if (pop)     rd_q <= ptr_inc(rd_q);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (push[v]) mem_q[wr_q] <= flit_in_if.flit;
        end
    end

endmodule

// File: tb/tb_noc_vc_splitter.sv
// Directed self-checking bench for noc_vc_splitter (CHANNELS=2, DEPTH=2).
// Inputs change just after posedge; outputs are checked at negedge.
module tb_noc_vc_splitter;
    import noc_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic [1:0] avail;
    logic       err;
    int         n_tests = 0;
    int         n_fail  = 0;

    noc_flit_if in_if ();
    noc_flit_if out_if [2] ();

    noc_vc_splitter #(.DEPTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_clear        (clr),
        .o_vc_available (avail),
        .o_error        (err),
        .flit_in_if     (in_if),
        .flit_out_if    (out_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic h, input logic t, input logic [1:0] vc,
                       input logic [15:0] d);
        noc_flit_t f;
        f.head = h;
        f.tail = t;
        f.vc   = vc;
        f.data = d;
        in_if.valid = 1'b1;
        in_if.flit  = f;
    endtask

    task automatic idle();
        in_if.valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        clr   = 1'b0;
        idle();
        in_if.flit      = '0;
        out_if[0].ready = 1'b1;
        out_if[1].ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // reset state
        @(negedge clk);
        check("rst_rdy", in_if.ready, 1);
        check("rst_avail", avail, 2'b11);
        check("rst_err", err, 0);
        check("rst_v0", out_if[0].valid, 0);
        check("rst_v1", out_if[1].valid, 0);
        tick();

        // single-flit packet on vc1
        put(1, 1, 1, 16'hA1);
        @(negedge clk);
        check("t1_rdy", in_if.ready, 1);
        tick();
        idle();
        @(negedge clk);
        check("t1_v1", out_if[1].valid, 1);
        check("t1_d1", out_if[1].flit.data, 16'hA1);
        check("t1_v0", out_if[0].valid, 0);
        tick();
        @(negedge clk);
        check("t1_v1_gone", out_if[1].valid, 0);
        tick();

        // 4-flit packet on vc0, body/tail carry vc=1
        for (int i = 0; i < 5; i++) begin
            if (i < 4) put(i == 0, i == 3, (i == 0) ? 2'd0 : 2'd1, 16'hB0 + 16'(i));
            else idle();
            @(negedge clk);
            if (i < 4) check("t2_rdy", in_if.ready, 1);
            if (i > 0) begin
                check("t2_v0", out_if[0].valid, 1);
                check("t2_d0", out_if[0].flit.data, 16'hB0 + 32'(i - 1));
            end
            check("t2_v1", out_if[1].valid, 0);
            tick();
        end
        @(negedge clk);
        check("t2_v0_end", out_if[0].valid, 0);
        tick();

        // vc0 stalled: fill, then pop while full
        out_if[0].ready = 1'b0;
        put(1, 0, 0, 16'hC0);
        @(negedge clk);
        check("t3_rdy0", in_if.ready, 1);
        check("t3_av0", avail, 2'b11);
        tick();
        put(0, 0, 0, 16'hC1);
        @(negedge clk);
        check("t3_rdy1", in_if.ready, 1);
        check("t3_av1", avail, 2'b10);
        tick();
        put(0, 1, 0, 16'hC2);
        @(negedge clk);
        check("t3_full", in_if.ready, 0);
        out_if[0].ready = 1'b1;
        #1;
        check("t3_nopath", in_if.ready, 0);
        check("t3_dC0", out_if[0].flit.data, 16'hC0);
        tick();
        @(negedge clk);
        check("t3_rdy_next", in_if.ready, 1);
        check("t3_dC1", out_if[0].flit.data, 16'hC1);
        tick();
        idle();
        @(negedge clk);
        check("t3_vC2", out_if[0].valid, 1);
        check("t3_dC2", out_if[0].flit.data, 16'hC2);
        check("t3_av2", avail, 2'b10);
        tick();
        @(negedge clk);
        check("t3_empty", out_if[0].valid, 0);
        check("t3_av3", avail, 2'b11);
        tick();

        // vc1 proceeds while vc0 is full
        out_if[0].ready = 1'b0;
        put(1, 0, 0, 16'hE0);
        tick();
        put(0, 1, 0, 16'hE1);
        tick();
        put(1, 1, 1, 16'hF0);
        @(negedge clk);
        check("t4_rdy_vc1", in_if.ready, 1);
        tick();
        idle();
        @(negedge clk);
        check("t4_v1", out_if[1].valid, 1);
        check("t4_d1", out_if[1].flit.data, 16'hF0);
        check("t4_av", avail, 2'b00);
        tick();
        @(negedge clk);
        check("t4_av2", avail, 2'b10);
        out_if[0].ready = 1'b1;
        #1;
        check("t4_dE0", out_if[0].flit.data, 16'hE0);
        tick();
        @(negedge clk);
        check("t4_dE1", out_if[0].flit.data, 16'hE1);
        tick();
        @(negedge clk);
        check("t4_v0_end", out_if[0].valid, 0);
        check("t4_av3", avail, 2'b11);
        tick();

        // out-of-range vc: whole packet dropped, error sticky
        put(1, 0, 3, 16'h60);
        @(negedge clk);
        check("t5_rdy0", in_if.ready, 1);
        tick();
        put(0, 0, 0, 16'h61);
        @(negedge clk);
        check("t5_rdy1", in_if.ready, 1);
        check("t5_err", err, 1);
        tick();
        put(0, 1, 1, 16'h62);
        @(negedge clk);
        check("t5_rdy2", in_if.ready, 1);
        check("t5_drop0", out_if[0].valid, 0);
        tick();
        put(1, 1, 0, 16'h63);
        @(negedge clk);
        check("t5_drop0b", out_if[0].valid, 0);
        check("t5_drop1", out_if[1].valid, 0);
        tick();
        idle();
        @(negedge clk);
        check("t5_v0", out_if[0].valid, 1);
        check("t5_d0", out_if[0].flit.data, 16'h63);
        check("t5_sticky", err, 1);
        tick();

        // i_clear mid-packet with vc1 full
        out_if[1].ready = 1'b0;
        put(1, 0, 1, 16'h70);
        tick();
        put(0, 0, 1, 16'h71);
        tick();
        idle();
        clr = 1'b1;
        @(negedge clk);
        check("t6_clr_rdy", in_if.ready, 0);
        check("t6_clr_v1", out_if[1].valid, 1);
        check("t6_clr_av", avail, 2'b01);
        tick();
        clr = 1'b0;
        out_if[1].ready = 1'b1;
        @(negedge clk);
        check("t6_v1", out_if[1].valid, 0);
        check("t6_av", avail, 2'b11);
        check("t6_err", err, 1);
        tick();
        put(1, 1, 0, 16'h72);
        @(negedge clk);
        check("t6_rdy", in_if.ready, 1);
        tick();
        idle();
        @(negedge clk);
        check("t6_idle_v0", out_if[0].valid, 1);
        check("t6_idle_d0", out_if[0].flit.data, 16'h72);
        check("t6_idle_v1", out_if[1].valid, 0);
        tick();

        // async reset mid-packet
        out_if[1].ready = 1'b0;
        put(1, 0, 1, 16'h80);
        tick();
        put(0, 0, 1, 16'h81);
        tick();
        idle();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t7_v1", out_if[1].valid, 0);
        check("t7_av", avail, 2'b11);
        check("t7_err", err, 0);
        tick();
        rst_n = 1'b1;
        out_if[1].ready = 1'b1;
        put(1, 1, 0, 16'h82);
        @(negedge clk);
        check("t7_rdy", in_if.ready, 1);
        tick();
        idle();
        @(negedge clk);
        check("t7_v0", out_if[0].valid, 1);
        check("t7_d0", out_if[0].flit.data, 16'h82);
        check("t7_v1b", out_if[1].valid, 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/noc_vc_splitter.md
Name: noc_vc_splitter

Overview:
- Receive-side counterpart of the per-port VC merger. Takes one flit stream from a link and demultiplexes it into CHANNELS per-virtual-channel streams.
- Each VC has its own output FIFO, so a stalled VC does not block other VCs at the same port.
- Packet-locked: the VC is taken from the head flit and held until the tail flit is accepted.
- Exports per-VC space status so the upstream VC arbiter can build its grants.

Parameters:
- CONFIG, NOC_DEFAULT_CONFIG, NoC configuration struct. Supplies flit format and virtual_channels.
- CHANNELS, CONFIG.virtual_channels, number of VCs (localparam, not overridable).
- DEPTH, 2, per-VC FIFO depth in flits. Legal values 2..16.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- i_clear  input  1  synchronous flush of all FIFOs and the packet lock
- o_vc_available  output  CHANNELS  bit v=1 when VC v FIFO holds at most DEPTH-2 flits (at least 2 free entries)
- o_error  output  1  sticky; set when a head flit carries vc >= CHANNELS
- flit_in_if  noc_flit_if.target  -  single input flit stream
- flit_out_if[CHANNELS]  noc_flit_if.initiator  -  per-VC output streams

Behaviour:
- Reset (rst_n=0, asynchronous):
  - all FIFOs empty; all flit_out_if valid=0
  - lock FSM in IDLE; locked_vc=0
  - o_error=0; o_vc_available all 1
  - flit_in_if.ready is combinational. With empty FIFOs it is 1 after reset release.
- Handshakes: valid/ready on every stream. A transfer occurs when valid&&ready at the rising edge. valid must not drop without a transfer (bench checks upstream).
- VC selection, sel_vc:
  - IDLE: sel_vc = flit_in.vc (head flit expected).
  - LOCKED: sel_vc = locked_vc. The vc field of body/tail flits is ignored.
- flit_in_if.ready = !full[sel_vc] && !i_clear. It never depends on other VCs' fullness.
- Write: an accepted flit is pushed into FIFO[sel_vc] unchanged.
- Lock FSM, updated on accepted flits only:
  - IDLE -> LOCKED on an accepted head with tail=0; locked_vc <= sel_vc.
  - IDLE -> IDLE on an accepted single-flit packet (head&tail).
  - LOCKED -> IDLE on an accepted tail.
  - LOCKED, accepted flit with head=1: treated as body. No state change; flit is written to locked_vc.
- Out-of-range VC (IDLE head with vc >= CHANNELS):
  - flit is accepted (ready=1) and dropped; o_error set.
  - if tail=0, FSM enters LOCKED-DROP; subsequent flits are accepted and dropped until the tail.
- Latency: a flit accepted at cycle N is presented on flit_out_if[v] at cycle N+1 (registered FIFO output). Order is preserved within a VC.
- Simultaneous push and pop on the same VC:
  - legal when full: pop frees the slot only at the edge, so ready stays 0 that cycle (no combinational pop-to-ready path).
  - legal when empty: no fall-through; the output appears next cycle.
- o_vc_available is registered from the post-update occupancy and is valid each cycle.
- i_clear=1:
  - next edge empties all FIFOs and returns the FSM to IDLE; o_error is kept.
  - flit_in_if.ready=0 and out valids are unaffected until that edge.
- Reset asserted mid-packet: everything discarded immediately. The first flit after release is treated as a head.
- Pointer arithmetic: per-VC read/write pointers of $clog2(DEPTH) bits plus a count of $clog2(DEPTH+1) bits. Wrap at DEPTH, non-power-of-two supported.

Test Plan:
- Single-flit packet vc=1 with CHANNELS=2, DEPTH=2 -> appears on flit_out_if[1] one cycle after acceptance; flit_out_if[0] valid stays 0; FSM stays IDLE.
- 4-flit packet on vc=0, body/tail flits carrying vc=1 -> all 4 flits on flit_out_if[0] in order; flit_out_if[1] never valid.
- Hold flit_out_if[0].ready=0 and send 3 flits on vc=0 -> first 2 accepted; ready=0 on the third; o_vc_available[0] drops to 0 after the 1st push. Then send to vc=1 after vc=0's packet tail -> vc=1 flow proceeds.
- Full VC0 with a simultaneous pop -> ready stays 0 that cycle, 1 the next cycle; no flit lost or duplicated (scoreboard).
- Head with vc=3 (CHANNELS=2), 3-flit packet -> all 3 accepted and dropped; o_error=1 and sticky; next valid packet is routed normally.
- i_clear pulse mid-packet with 2 flits queued in VC1 -> next cycle VC1 is empty, FSM IDLE, o_vc_available=all 1; rst_n pulse mid-packet gives the same result asynchronously.
